map1_fetch: RTL and testbench

MAP1_FETCH -- requirements
Module: map1_fetch

---
 rtl/map1_pkg.sv | 25 ++
 rtl/map1_sync_delay.sv | 41 ++++
 rtl/map1_fetch.sv | 161 ++++++++++++++++
 tb/tb_map1_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/map1_pkg.sv
// Shared geometry constants and FSM state type for the map fetch pipeline.
package map1_pkg;

   localparam int MAP_W     = 320;
   localparam int MAP_H     = 240;
   localparam int SCALE     = 2;
   localparam int ROM_DEPTH = 76800;
   localparam int ADDR_W    = 17;
   localparam int LAT       = 3;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      HBLANK     = 2'd1,
      ACTIVE     = 2'd2
   } fetch_state_t;

   // Row start address for a map row; only used at frame start, so the
   // shift-and-add form (row*256 + row*64) stays off the per-line path.
   function automatic logic [ADDR_W-1:0] row_to_base(input logic [7:0] row);
      logic [ADDR_W-1:0] r;
      r = {{(ADDR_W-8){1'b0}}, row};
      return (r << 8) + (r << 6);
   endfunction

endpackage

// File: rtl/map1_sync_delay.sv
// Fixed-depth shift register with a per-bit reset value, used to align
// display enable and syncs with the fetched palette index.
module map1_sync_delay
   import map1_pkg::*;
#(
   parameter int               DEPTH   = 3,
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_reg;
   logic [DEPTH-1:0][WIDTH-1:0] stage_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign stage_next[gi] = d;
         end else begin : g_rest
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   // Advance every stage by one cycle; reset loads the inactive pattern.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_reg <= {DEPTH{RST_VAL}};
      end else begin
         stage_reg <= stage_next;
      end
   end

   assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/map1_fetch.sv
// Map pixel fetch: walks a 320x240 map at 2x scaling in both directions,
// issues ROM addresses and returns the palette index aligned with the syncs.
module map1_fetch
   import map1_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              de_i,
   input  logic              hs_n_i,
   input  logic              vs_n_i,
   input  logic [7:0]        scroll_y,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        index_o,
   output logic              de_o,
   output logic              hs_n_o,
   output logic              vs_n_o,
   output logic              valid_o
);

   localparam logic [8:0]        COL_LAST  = 9'(MAP_W - 1);
   localparam logic [7:0]        ROW_LAST  = 8'(MAP_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(MAP_W);

   fetch_state_t      state_reg, state_next;
   logic              vs_prev_reg;
   logic              vs_fall;
   logic              fetch;
   logic              line_end;
   logic [7:0]        row_load;

   logic [7:0]        row_reg;
   logic [ADDR_W-1:0] row_base_reg;
   logic [8:0]        col_reg;
   logic              phase_reg;
   logic              parity_reg;
   logic [ADDR_W-1:0] rom_addr_reg;

   logic              fetch_p1_reg;
   logic              fetch_p2_reg;
   logic [3:0]        index_reg;
   logic              valid_reg;

   assign vs_fall  = vs_prev_reg & ~vs_n_i;
   assign row_load = (scroll_y < 8'(MAP_H)) ? scroll_y : 8'd0;

   // Previous vsync level for frame-start edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_prev_reg <= 1'b1;
      end else begin
         vs_prev_reg <= vs_n_i;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= WAIT_FRAME;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state plus fetch / end-of-line strobes; frame start overrides all.
   always_comb begin
      state_next = state_reg;
      fetch      = 1'b0;
      line_end   = 1'b0;
      if (vs_fall) begin
         state_next = HBLANK;
      end else begin
         case (state_reg)
            WAIT_FRAME: state_next = WAIT_FRAME;
            HBLANK: begin
               if (de_i) begin
                  state_next = ACTIVE;
                  fetch      = 1'b1;
               end
            end
            ACTIVE: begin
               if (de_i) begin
                  fetch = 1'b1;
               end else begin
                  state_next = HBLANK;
                  line_end   = 1'b1;
               end
            end
            default: state_next = WAIT_FRAME;
         endcase
      end
   end

   // Map position counters and ROM address register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_reg      <= '0;
         row_base_reg <= '0;
         col_reg      <= '0;
         phase_reg    <= 1'b0;
         parity_reg   <= 1'b0;
         rom_addr_reg <= '0;
      end else if (vs_fall) begin
         row_reg      <= row_load;
         row_base_reg <= row_to_base(row_load);
         col_reg      <= '0;
         phase_reg    <= 1'b0;
         parity_reg   <= 1'b0;
      end else if (fetch) begin
         rom_addr_reg <= row_base_reg + {{(ADDR_W-9){1'b0}}, col_reg};
         phase_reg    <= ~phase_reg;
         if (phase_reg && (col_reg != COL_LAST)) begin
            col_reg <= col_reg + 9'd1;
         end
      end else if (line_end) begin
         col_reg    <= '0;
         phase_reg  <= 1'b0;
         parity_reg <= ~parity_reg;
         if (parity_reg) begin
            if (row_reg == ROW_LAST) begin
               row_reg      <= '0;
               row_base_reg <= '0;
            end else begin
               row_reg      <= row_reg + 8'd1;
               row_base_reg <= row_base_reg + ROW_STEP;
            end
         end
      end
   end

   // Valid tracking alongside the ROM read, then the gated index register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_p1_reg <= 1'b0;
         fetch_p2_reg <= 1'b0;
         index_reg    <= '0;
         valid_reg    <= 1'b0;
      end else begin
         fetch_p1_reg <= fetch;
         fetch_p2_reg <= fetch_p1_reg;
         index_reg    <= fetch_p2_reg ? rom_q : 4'd0;
         valid_reg    <= fetch_p2_reg;
      end
   end

   map1_sync_delay #(
      .DEPTH   (LAT),
      .WIDTH   (3),
      .RST_VAL (3'b011)
   ) u_sync_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .d       ({de_i, hs_n_i, vs_n_i}),
      .q       ({de_o, hs_n_o, vs_n_o})
   );

   assign rom_addr = rom_addr_reg;
   assign index_o  = index_reg;
   assign valid_o  = valid_reg;

endmodule

// File: tb/tb_map1_fetch.sv
// Directed bench for map1_fetch: table of frames plus hand sequences for
// long lines, vsync during an active pixel and mid-line reset.
module tb_map1_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        de_i = 1'b0;
   logic        hs_n_i = 1'b1;
   logic        vs_n_i = 1'b1;
   logic [7:0]  scroll_y = 8'd0;
   logic [16:0] rom_addr;
   logic [3:0]  rom_q = 4'd0;
   logic [3:0]  index_o;
   logic        de_o, hs_n_o, vs_n_o, valid_o;

   int total = 0;
   int bad   = 0;
   logic mon_en = 1'b0;

   // Expected per-cycle fetch flag and address set by the stimulus.
   logic        exp_fetch = 1'b0;
   logic [16:0] exp_addr  = '0;

   logic [2:0]  sync_h  [0:2];
   logic        fetch_h [0:2];
   logic [3:0]  idx_h   [0:2];

   map1_fetch dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .de_i     (de_i),
      .hs_n_i   (hs_n_i),
      .vs_n_i   (vs_n_i),
      .scroll_y (scroll_y),
      .rom_addr (rom_addr),
      .rom_q    (rom_q),
      .index_o  (index_o),
      .de_o     (de_o),
      .hs_n_o   (hs_n_o),
      .vs_n_o   (vs_n_o),
      .valid_o  (valid_o)
   );

   always #5 clk = ~clk;

   // ROM model: content at address a is a mod 16, one-cycle read.
   always @(posedge clk) rom_q <= rom_addr[3:0];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Three-cycle history of stimulus and expected fetches.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin
            sync_h[k]  <= 3'b011;
            fetch_h[k] <= 1'b0;
            idx_h[k]   <= 4'd0;
         end
      end else begin
         sync_h[0]  <= {de_i, hs_n_i, vs_n_i};
         fetch_h[0] <= exp_fetch;
         idx_h[0]   <= exp_addr[3:0];
         for (int k = 1; k < 3; k++) begin
            sync_h[k]  <= sync_h[k-1];
            fetch_h[k] <= fetch_h[k-1];
            idx_h[k]   <= idx_h[k-1];
         end
      end
   end

   // Output alignment checks, one set per cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("sync_delay", int'({de_o, hs_n_o, vs_n_o}), int'(sync_h[2]));
         chk("valid_o", int'(valid_o), int'(fetch_h[2]));
         chk("index_o", int'(index_o), fetch_h[2] ? int'(idx_h[2]) : 0);
      end
   end

   task automatic drive(input logic de, input logic hs, input logic vs,
                        input logic f, input int a);
      de_i      = de;
      hs_n_i    = hs;
      vs_n_i    = vs;
      exp_fetch = f;
      exp_addr  = 17'(a);
      @(posedge clk);
      #1;
   endtask

   task automatic hblank(input int n);
      for (int h = 0; h < n; h++)
         drive(1'b0, (h >= 4 && h < 12) ? 1'b0 : 1'b1, 1'b1, 1'b0, 0);
   endtask

   task automatic vs_pulse(input logic [7:0] sc);
      scroll_y = sc;
      for (int h = 0; h < 6; h++) drive(1'b0, 1'b1, (h < 3) ? 1'b0 : 1'b1, 1'b0, 0);
   endtask

   // One fetched line; address is base + pixel/2 saturating at column 319.
   task automatic run_line(input int npix, input int base);
      int a;
      a = base;
      for (int p = 0; p < npix; p++) begin
         a = base + (((p / 2) > 319) ? 319 : (p / 2));
         drive(1'b1, 1'b1, 1'b1, 1'b1, a);
         chk("rom_addr", int'(rom_addr), a);
      end
      hblank(24);
      chk("rom_addr_hold", int'(rom_addr), a);
   endtask

   typedef struct {
      logic [7:0] scroll;
      logic [7:0] mid_scroll;
      int         base [4];
   } frame_vec_t;

   frame_vec_t vecs [4];

   initial begin
      vecs[0] = '{scroll: 8'd0,   mid_scroll: 8'd77, base: '{0, 0, 320, 320}};
      vecs[1] = '{scroll: 8'd239, mid_scroll: 8'd239, base: '{76480, 76480, 0, 0}};
      vecs[2] = '{scroll: 8'd250, mid_scroll: 8'd3,  base: '{0, 0, 320, 320}};
      vecs[3] = '{scroll: 8'd100, mid_scroll: 8'd100, base: '{32000, 32000, 32320, 32320}};

      // Reset state
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_index", int'(index_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_syncs", int'({de_o, hs_n_o, vs_n_o}), 3);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Before any frame start, active pixels are ignored.
      for (int p = 0; p < 20; p++) drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
      hblank(10);
      chk("wait_frame_addr", int'(rom_addr), 0);

      // Frame table: four lines each, scroll change after line 0 ignored.
      for (int v = 0; v < 4; v++) begin
         vs_pulse(vecs[v].scroll);
         for (int l = 0; l < 4; l++) begin
            if (l == 1) scroll_y = vecs[v].mid_scroll;
            run_line(640, vecs[v].base[l]);
         end
      end

      // Overlong line saturates at column 319; next lines start cleanly.
      vs_pulse(8'd0);
      run_line(700, 0);
      run_line(640, 0);
      run_line(640, 320);

      // Vsync falls during an active pixel: reload wins, fetch resumes at new row.
      vs_pulse(8'd0);
      run_line(640, 0);
      for (int p = 0; p < 100; p++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b1, p / 2);
         chk("pre_vs_addr", int'(rom_addr), p / 2);
      end
      scroll_y = 8'd10;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("vs_active_hold", int'(rom_addr), 49);
      for (int p = 0; p < 20; p++) begin
         drive(1'b1, 1'b1, (p < 2) ? 1'b0 : 1'b1, 1'b1, 3200 + p / 2);
         chk("post_vs_addr", int'(rom_addr), 3200 + p / 2);
      end
      hblank(24);
      run_line(640, 3200);
      run_line(640, 3520);

      // Mid-line reset abandons the line until the next frame start.
      vs_pulse(8'd0);
      for (int p = 0; p < 30; p++) drive(1'b1, 1'b1, 1'b1, 1'b1, p / 2);
      reset_n = 1'b0;
      #1;
      chk("midrst_index", int'(index_o), 0);
      chk("midrst_valid", int'(valid_o), 0);
      chk("midrst_syncs", int'({hs_n_o, vs_n_o}), 3);
      chk("midrst_rom_addr", int'(rom_addr), 0);
      for (int p = 0; p < 3; p++) drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
      reset_n = 1'b1;
      for (int p = 0; p < 40; p++) drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
      hblank(24);
      for (int p = 0; p < 40; p++) drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
      hblank(24);
      chk("post_rst_addr", int'(rom_addr), 0);
      vs_pulse(8'd0);
      run_line(640, 0);

      hblank(5);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
